vdp_copper: RTL and testbench



---
 rtl/vdp_copper_pkg.sv | 32 +++
 rtl/vdp_copper_if.sv | 29 ++
 rtl/vdp_copper.sv | 131 +++++++++++++
 tb/tb_vdp_copper.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_copper_pkg.sv
// Shared definitions for the VDP copper: opcodes, FSM states and command-word field positions.
package vdp_copper_defs;

   localparam logic [2:0] OP_HALT   = 3'b000;
   localparam logic [2:0] OP_WAIT_Y = 3'b001;
   localparam logic [2:0] OP_WAIT_X = 3'b010;
   localparam logic [2:0] OP_WRITE  = 3'b011;
   localparam logic [2:0] OP_JUMP   = 3'b100;

   localparam int OP_LSB      = 13;
   localparam int REG_LSB     = 0;
   localparam int REG_WIDTH   = 5;
   localparam int COUNT_LSB   = 5;
   localparam int COUNT_WIDTH = 5;
   localparam int INC_BIT     = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_WAIT_Y,
      ST_WAIT_X,
      ST_DATA_FETCH,
      ST_DATA,
      ST_HALTED
   } state_e;

   function automatic logic [2:0] cmd_op(input logic [15:0] word);
      return word[OP_LSB +: 3];
   endfunction

endpackage

// File: rtl/vdp_copper_if.sv
// Copper program-RAM read port plus copper register-write port toward the VDP host interface.
interface vdp_copper_if #(
   parameter int RAM_ADDR_WIDTH = 10
);
   logic [RAM_ADDR_WIDTH-1:0] ram_read_address;
   logic [15:0]               ram_read_data;
   logic                      host_write_en;
   logic                      cop_write_en;
   logic [4:0]                cop_write_address;
   logic [15:0]               cop_write_data;

   modport master (
      output ram_read_address,
      output cop_write_en,
      output cop_write_address,
      output cop_write_data,
      input  ram_read_data,
      input  host_write_en
   );

   modport slave (
      input  ram_read_address,
      input  cop_write_en,
      input  cop_write_address,
      input  cop_write_data,
      output ram_read_data,
      output host_write_en
   );
endinterface

// File: rtl/vdp_copper.sv
// Raster-synchronised register sequencer: walks a command list in program RAM, waits on the
// beam and issues VDP register writes, yielding to CPU writes on the shared register port.
module vdp_copper
   import vdp_copper_defs::*;
#(
   parameter int RAM_ADDR_WIDTH = 10,
   parameter int RASTER_WIDTH   = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [RAM_ADDR_WIDTH-1:0] start_address,
   input  logic                      frame_start,
   input  logic [RASTER_WIDTH-1:0]   raster_x,
   input  logic [RASTER_WIDTH-1:0]   raster_y,
   output logic                      halted,
   vdp_copper_if.master              bus
);

   localparam logic [RAM_ADDR_WIDTH-1:0] PC_ONE = 1;

   state_e                    state_reg, state_next;
   logic [RAM_ADDR_WIDTH-1:0] pc_reg, pc_next;
   logic [REG_WIDTH-1:0]      reg_addr_reg, reg_addr_next;
   logic [COUNT_WIDTH-1:0]    count_reg, count_next;
   logic                      inc_reg, inc_next;
   logic [RASTER_WIDTH-1:0]   target_reg, target_next;

   logic [15:0] cmd;
   logic        write_accept;
   logic        unused_cmd_bits;

   assign cmd             = bus.ram_read_data;
   assign unused_cmd_bits = ^cmd[12:11];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         pc_reg       <= '0;
         reg_addr_reg <= '0;
         count_reg    <= '0;
         inc_reg      <= 1'b0;
         target_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         reg_addr_reg <= reg_addr_next;
         count_reg    <= count_next;
         inc_reg      <= inc_next;
         target_reg   <= target_next;
      end
   end

   // A data word is only consumed when the CPU is not using the register port this cycle.
   assign write_accept = (state_reg == ST_DATA) && enable && !bus.host_write_en;

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      reg_addr_next = reg_addr_reg;
      count_next    = count_reg;
      inc_next      = inc_reg;
      target_next   = target_reg;

      if (!enable) begin
         state_next = ST_IDLE;
      end else if (frame_start) begin
         state_next = ST_FETCH;
         pc_next    = start_address;
      end else begin
         case (state_reg)
            ST_IDLE:       state_next = ST_IDLE;
            ST_FETCH:      state_next = ST_DECODE;
            ST_DECODE: begin
               case (cmd_op(cmd))
                  OP_WAIT_Y: begin
                     target_next = cmd[RASTER_WIDTH-1:0];
                     pc_next     = pc_reg + PC_ONE;
                     state_next  = ST_WAIT_Y;
                  end
                  OP_WAIT_X: begin
                     target_next = cmd[RASTER_WIDTH-1:0];
                     pc_next     = pc_reg + PC_ONE;
                     state_next  = ST_WAIT_X;
                  end
                  OP_WRITE: begin
                     reg_addr_next = cmd[REG_LSB +: REG_WIDTH];
                     count_next    = cmd[COUNT_LSB +: COUNT_WIDTH];
                     inc_next      = cmd[INC_BIT];
                     pc_next       = pc_reg + PC_ONE;
                     state_next    = ST_DATA_FETCH;
                  end
                  OP_JUMP: begin
                     pc_next    = cmd[RAM_ADDR_WIDTH-1:0];
                     state_next = ST_FETCH;
                  end
                  default:   state_next = ST_HALTED;
               endcase
            end
            ST_WAIT_Y: begin
               if (raster_y >= target_reg) state_next = ST_FETCH;
            end
            ST_WAIT_X: begin
               if (raster_x >= target_reg) state_next = ST_FETCH;
            end
            ST_DATA_FETCH: state_next = ST_DATA;
            ST_DATA: begin
               if (write_accept) begin
                  pc_next = pc_reg + PC_ONE;
                  if (inc_reg) reg_addr_next = reg_addr_reg + 5'd1;
                  if (count_reg == '0) begin
                     state_next = ST_FETCH;
                  end else begin
                     count_next = count_reg - 5'd1;
                     state_next = ST_DATA_FETCH;
                  end
               end
            end
            ST_HALTED:     state_next = ST_HALTED;
            default:       state_next = ST_IDLE;
         endcase
      end
   end

   assign bus.ram_read_address  = pc_reg;
   assign bus.cop_write_en      = write_accept;
   assign bus.cop_write_address = reg_addr_reg;
   assign bus.cop_write_data    = cmd;
   assign halted                = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_vdp_copper.sv
// Self-checking bench for vdp_copper: RAM model, write scoreboard and per-feature scenarios.
module tb_vdp_copper;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [9:0] start_address;
   logic       frame_start;
   logic [9:0] raster_x;
   logic [9:0] raster_y;
   logic       halted;

   vdp_copper_if #(.RAM_ADDR_WIDTH(10)) bus ();

   vdp_copper #(.RAM_ADDR_WIDTH(10), .RASTER_WIDTH(10)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .start_address (start_address),
      .frame_start   (frame_start),
      .raster_x      (raster_x),
      .raster_y      (raster_y),
      .halted        (halted),
      .bus           (bus)
   );

   typedef struct {
      logic [4:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic [15:0] mem [0:1023];
   int          errors = 0;
   int          checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.ram_read_data <= mem[bus.ram_read_address];

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.host_write_en) begin
         checks++;
         if (bus.cop_write_en) begin
            errors++;
            $display("FAIL collision cop_write_en=1 while host_write_en=1 required cop_write_en=0");
         end
      end
      if (bus.cop_write_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h required no write", bus.cop_write_address, bus.cop_write_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bus.cop_write_address !== e.a || bus.cop_write_data !== e.d) begin
               errors++;
               $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h", bus.cop_write_address, bus.cop_write_data, e.a, e.d);
            end else begin
               $display("write addr=%0d data=%h ok", e.a, e.d);
            end
         end
      end
   end

   task automatic push_exp(input logic [4:0] a, input logic [15:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Leaves the caller at #1 into cycle T+1, where T is the cycle frame_start was high.
   task automatic pulse_frame(input logic [9:0] addr);
      @(posedge clk); #1;
      start_address = addr;
      frame_start   = 1'b1;
      @(posedge clk); #1;
      frame_start   = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ram_read_address !== 10'd0 || bus.cop_write_en !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset got addr=%0d en=%b halted=%b required 0 0 0", bus.ram_read_address, bus.cop_write_en, halted);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic_write;
      push_exp(5'd3, 16'h1234);
      push_exp(5'd3, 16'hABCD);
      pulse_frame(10'h000);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++;
         if (bus.cop_write_en !== ((k == 4) || (k == 6))) begin
            errors++;
            $display("FAIL basic_strobe T+%0d got=%b required=%b", k, bus.cop_write_en, (k == 4) || (k == 6));
         end
         if (k <= 7 || k >= 9) begin
            checks++;
            if (halted !== (k >= 9)) begin
               errors++;
               $display("FAIL basic_halted T+%0d got=%b required=%b", k, halted, k >= 9);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_drain pending=%0d required 0", exp_q.size());
      end
      $display("test_basic_write done");
   endtask

   task automatic test_incr_wrap;
      push_exp(5'd30, 16'h1111);
      push_exp(5'd31, 16'h2222);
      push_exp(5'd0,  16'h3333);
      pulse_frame(10'h010);
      for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
      checks++;
      if (halted !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL incr_wrap halted=%b pending=%0d required halted=1 pending=0", halted, exp_q.size());
      end
      $display("test_incr_wrap done");
   endtask

   task automatic test_wait_y;
      raster_y = 10'd0;
      pulse_frame(10'h020);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         raster_y = 10'd10 + 10'(k * 4);
         checks++;
         if (bus.cop_write_en !== 1'b0) begin
            errors++;
            $display("FAIL wait_early cycle=%0d got en=%b required 0", k, bus.cop_write_en);
         end
      end
      push_exp(5'd5, 16'h0001);
      @(posedge clk); #1 raster_y = 10'd100;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         checks++;
         if (bus.cop_write_en !== (k == 4)) begin
            errors++;
            $display("FAIL wait_strobe W+%0d got=%b required=%b", k, bus.cop_write_en, k == 4);
         end
      end
      $display("test_wait_y done");
   endtask

   task automatic test_stall;
      push_exp(5'd7, 16'hBEEF);
      push_exp(5'd7, 16'hCAFE);
      pulse_frame(10'h030);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++;
         if (bus.cop_write_en !== ((k == 7) || (k == 9))) begin
            errors++;
            $display("FAIL stall_strobe T+%0d got=%b required=%b", k, bus.cop_write_en, (k == 7) || (k == 9));
         end
         if (k >= 4 && k <= 6) begin
            checks++;
            if (bus.cop_write_address !== 5'd7 || bus.cop_write_data !== 16'hBEEF) begin
               errors++;
               $display("FAIL stall_hold T+%0d got addr=%0d data=%h required 7 beef", k, bus.cop_write_address, bus.cop_write_data);
            end
         end
         @(posedge clk); #1;
         bus.host_write_en = (k + 1 >= 4) && (k + 1 <= 6);
      end
      bus.host_write_en = 1'b0;
      $display("test_stall done");
   endtask

   task automatic test_jump;
      push_exp(5'd3, 16'h1234);
      push_exp(5'd3, 16'hABCD);
      pulse_frame(10'h3FF);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checks++;
         if (bus.cop_write_en !== (k == 6)) begin
            errors++;
            $display("FAIL jump_strobe T+%0d got=%b required=%b", k, bus.cop_write_en, k == 6);
         end
      end
      for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
      checks++;
      if (halted !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL jump_end halted=%b pending=%0d required halted=1 pending=0", halted, exp_q.size());
      end
      $display("test_jump done");
   endtask

   task automatic test_abandon;
      push_exp(5'd9, 16'h0101);
      push_exp(5'd1, 16'h5555);
      pulse_frame(10'h040);
      repeat (4) @(posedge clk);
      #1;
      start_address = 10'h050;
      frame_start   = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      for (int i = 0; i < 30 && !halted; i++) @(negedge clk);
      checks++;
      if (halted !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL abandon halted=%b pending=%0d required halted=1 pending=0", halted, exp_q.size());
      end
      $display("test_abandon done");
   endtask

   task automatic test_enable;
      pulse_frame(10'h040);
      @(posedge clk); #1;
      @(posedge clk); #1 enable = 1'b0;
      for (int k = 0; k < 15; k++) begin
         frame_start = (k == 5);
         if (k == 10) enable = 1'b1;
         @(negedge clk);
         checks++;
         if (bus.cop_write_en !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL enable_idle k=%0d got en=%b halted=%b required 0 0", k, bus.cop_write_en, halted);
         end
         @(posedge clk); #1;
      end
      frame_start = 1'b0;
      $display("test_enable done");
   endtask

   task automatic test_reset_mid;
      push_exp(5'd9, 16'h0101);
      pulse_frame(10'h040);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cop_write_en !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_data got en=%b required 1", bus.cop_write_en);
      end
      @(negedge clk);
      checks++;
      if (bus.cop_write_en !== 1'b0 || bus.ram_read_address !== 10'd0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got en=%b addr=%0d halted=%b required 0 0 0", bus.cop_write_en, bus.ram_read_address, halted);
      end
      @(posedge clk); #1 reset = 1'b0;
      $display("test_reset_mid done");
   endtask

   task automatic test_undef;
      pulse_frame(10'h060);
      for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
      checks++;
      if (halted !== 1'b1 || bus.ram_read_address !== 10'h060) begin
         errors++;
         $display("FAIL undef got halted=%b addr=%h required 1 060", halted, bus.ram_read_address);
      end
      $display("test_undef done");
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[10'h000] = 16'h6023; mem[10'h001] = 16'h1234; mem[10'h002] = 16'hABCD;
      mem[10'h010] = 16'h645E; mem[10'h011] = 16'h1111; mem[10'h012] = 16'h2222; mem[10'h013] = 16'h3333;
      mem[10'h020] = 16'h2064; mem[10'h021] = 16'h6005; mem[10'h022] = 16'h0001;
      mem[10'h030] = 16'h6027; mem[10'h031] = 16'hBEEF; mem[10'h032] = 16'hCAFE;
      mem[10'h040] = 16'h6069; mem[10'h041] = 16'h0101; mem[10'h042] = 16'h0202;
      mem[10'h043] = 16'h0303; mem[10'h044] = 16'h0404;
      mem[10'h050] = 16'h6001; mem[10'h051] = 16'h5555;
      mem[10'h060] = 16'hE000;
      mem[10'h3FF] = 16'h8000;

      enable            = 1'b1;
      start_address     = 10'd0;
      frame_start       = 1'b0;
      raster_x          = 10'd0;
      raster_y          = 10'd0;
      bus.host_write_en = 1'b0;

      test_reset();
      test_basic_write();
      test_incr_wrap();
      test_wait_y();
      test_stall();
      test_jump();
      test_abandon();
      test_enable();
      test_reset_mid();
      test_undef();

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
